// File: rtl/hazard_stall_ctrl.sv
// Hazard scheduler for the 5-stage MIPS core: Tuse/Tnew data stalls plus MDU busy countdown.
// Optional STALL_PERF_EN macro adds data-stall and MDU-only-stall cycle counters.
module hazard_stall_ctrl #(
   parameter int MULT_LAT = 5,
   parameter int DIV_LAT  = 10,
   parameter int CNT_W    = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       rs_D,
   input  logic [4:0]       rt_D,
   input  logic [1:0]       tuse_rs_D,
   input  logic [1:0]       tuse_rt_D,
   input  logic             md_D,
   input  logic [4:0]       A3_E,
   input  logic [1:0]       tnew_E,
   input  logic [4:0]       A3_M,
   input  logic [1:0]       tnew_M,
   input  logic             start_E,
   input  logic             div_E,
`ifdef STALL_PERF_EN
   output logic [31:0]      perf_data_stalls,
   output logic [31:0]      perf_md_stalls,
`endif
   output logic             stall_F,
   output logic             stall_D,
   output logic             flush_E,
   output logic             md_busy,
   output logic [CNT_W-1:0] md_cnt
);

   logic stall_rs;
   logic stall_rt;
   logic stall_md;
   logic stall;

   // tuse = 3 can never be below a Tnew of at most 2, so "not used" needs no special case.
   assign stall_rs = (rs_D != 5'd0) &&
                     (((rs_D == A3_E) && (tuse_rs_D < tnew_E)) ||
                      ((rs_D == A3_M) && (tuse_rs_D < tnew_M)));

   assign stall_rt = (rt_D != 5'd0) &&
                     (((rt_D == A3_E) && (tuse_rt_D < tnew_E)) ||
                      ((rt_D == A3_M) && (tuse_rt_D < tnew_M)));

   // Including start_E covers the instruction directly behind a mult/div in its issue cycle.
   assign md_busy  = start_E || (md_cnt != '0);
   assign stall_md = md_D && md_busy;
   assign stall    = stall_rs || stall_rt || stall_md;

   assign stall_F = stall && !reset;
   assign stall_D = stall && !reset;
   assign flush_E = stall && !reset;

   always_ff @(posedge clk) begin
      if (reset)
         md_cnt <= '0;
      else if (start_E)
         md_cnt <= div_E ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
      else if (md_cnt != '0)
         md_cnt <= md_cnt - 1'b1;
   end

`ifdef STALL_PERF_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         perf_data_stalls <= '0;
         perf_md_stalls   <= '0;
      end else begin
         if (stall_rs || stall_rt)
            perf_data_stalls <= perf_data_stalls + 32'd1;
         else if (stall_md)
            perf_md_stalls <= perf_md_stalls + 32'd1;
      end
   end
`endif

endmodule
